uart_port_fifo: RTL

Parametrised single-clock UART port with internal TX and RX FIFOs, a programmable baud divisor and optional parity. It replaces the fixed 115200/8N1 port that relied on separate macro cells. It sits between the CPU I/O bus and the board serial pins. Received data is signalled through the same int_req/int_ack interrupt handshake. RX framing and overrun errors are reported on sticky flags.

---
 rtl/uart_port_fifo_if.sv | 23 ++
 rtl/uart_port_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_port_fifo_if.sv
// CPU-side bus of the UART port: TX write strobe, RX interrupt handshake and sticky error flags.
interface uart_port_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic                 write_enable;
  logic [DATA_BITS-1:0] data_in;
  logic                 write_busy;
  logic                 int_req;
  logic                 int_ack;
  logic [DATA_BITS-1:0] data_out;
  logic                 err_clr;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output write_enable, data_in, int_ack, err_clr,
    input  write_busy, int_req, data_out, rx_frame_err, rx_overrun
  );
  modport slave (
    input  write_enable, data_in, int_ack, err_clr,
    output write_busy, int_req, data_out, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_port_fifo.sv
// UART port with TX/RX FIFOs, 16x-oversampled baud tick, optional parity and an
// int_req/int_ack handshake that presents received characters to the CPU.
module uart_port_fifo #(
  parameter int BAUD_DIV   = 27,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_AW    = 4,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  uart_port_fifo_if.slave bus,
  output logic            TxD,
  input  logic            RxD
);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW+1)'(1);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Baud tick generator
  logic [CW-1:0] baud_cnt;
  logic          tick;
  assign tick = (baud_cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + CW'(1);
  end

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [DEPTH];
  logic [FIFO_AW:0]     tx_wp, tx_rp;
  logic                 tx_full, tx_empty, tx_push, tx_pop, we_q;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) &&
                    (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  // A pop in the same cycle frees a slot, so a write while full still lands.
  assign tx_push  = bus.write_enable & ~we_q & (~tx_full | tx_pop);
  assign tx_head  = tx_mem[tx_rp[FIFO_AW-1:0]];
  assign bus.write_busy = tx_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q  <= 1'b0;
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      we_q <= bus.write_enable;
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= bus.data_in;
  end

  // TX framer
  state_t               tx_st, tx_st_nxt;
  logic [3:0]           tx_tk, tx_tk_nxt, tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
  logic                 tx_par, tx_par_nxt, txd_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st  <= S_IDLE;
      tx_tk  <= '0;
      tx_bit <= '0;
      TxD    <= 1'b1;
    end else begin
      tx_st  <= tx_st_nxt;
      tx_tk  <= tx_tk_nxt;
      tx_bit <= tx_bit_nxt;
      TxD    <= txd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh  <= tx_sh_nxt;
    tx_par <= tx_par_nxt;
  end

  always_comb begin
    tx_st_nxt  = tx_st;
    tx_tk_nxt  = tx_tk;
    tx_bit_nxt = tx_bit;
    tx_sh_nxt  = tx_sh;
    tx_par_nxt = tx_par;
    tx_pop     = 1'b0;
    if (tick) begin
      tx_tk_nxt = tx_tk + 4'd1;
      case (tx_st)
        S_IDLE: begin
          tx_tk_nxt = '0;
          if (!tx_empty) tx_pop = 1'b1;
        end
        S_START: if (tx_tk == 4'd15) begin
          tx_st_nxt  = S_DATA;
          tx_bit_nxt = '0;
        end
        S_DATA: if (tx_tk == 4'd15) begin
          tx_sh_nxt  = tx_sh >> 1;
          tx_bit_nxt = tx_bit + 4'd1;
          if (tx_bit == LAST_BIT) tx_st_nxt = PARITY_EN ? S_PARITY : S_STOP;
        end
        S_PARITY: if (tx_tk == 4'd15) tx_st_nxt = S_STOP;
        S_STOP: if (tx_tk == 4'd15) begin
          if (!tx_empty) tx_pop = 1'b1;
          else           tx_st_nxt = S_IDLE;
        end
        default: tx_st_nxt = S_IDLE;
      endcase
      if (tx_pop) begin
        tx_st_nxt  = S_START;
        tx_tk_nxt  = '0;
        tx_sh_nxt  = tx_head;
        tx_par_nxt = (^tx_head) ^ PARITY_ODD;
      end
    end
    case (tx_st_nxt)
      S_START:  txd_nxt = 1'b0;
      S_DATA:   txd_nxt = tx_sh_nxt[0];
      S_PARITY: txd_nxt = tx_par_nxt;
      default:  txd_nxt = 1'b1;
    endcase
  end

  // RX synchroniser and deframer
  logic                 rx_s1, rx_s2;
  state_t               rx_st, rx_st_nxt;
  logic [3:0]           rx_tk, rx_tk_nxt, rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_nxt;
  logic                 rx_pbit, rx_pbit_nxt, rx_done, rx_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_st  <= S_IDLE;
      rx_tk  <= '0;
      rx_bit <= '0;
    end else begin
      rx_s1  <= RxD;
      rx_s2  <= rx_s1;
      rx_st  <= rx_st_nxt;
      rx_tk  <= rx_tk_nxt;
      rx_bit <= rx_bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    rx_sh   <= rx_sh_nxt;
    rx_pbit <= rx_pbit_nxt;
  end

  always_comb begin
    rx_st_nxt   = rx_st;
    rx_tk_nxt   = rx_tk;
    rx_bit_nxt  = rx_bit;
    rx_sh_nxt   = rx_sh;
    rx_pbit_nxt = rx_pbit;
    rx_done     = 1'b0;
    rx_bad      = 1'b0;
    if (tick) begin
      rx_tk_nxt = rx_tk + 4'd1;
      case (rx_st)
        S_IDLE: begin
          rx_tk_nxt = '0;
          if (!rx_s2) rx_st_nxt = S_START;
        end
        // Half a bit into the start bit: still low means a real frame.
        S_START: if (rx_tk == 4'd7) begin
          rx_tk_nxt  = '0;
          rx_bit_nxt = '0;
          rx_st_nxt  = rx_s2 ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_tk == 4'd15) begin
          rx_sh_nxt  = {rx_s2, rx_sh[DATA_BITS-1:1]};
          rx_bit_nxt = rx_bit + 4'd1;
          if (rx_bit == LAST_BIT) rx_st_nxt = PARITY_EN ? S_PARITY : S_STOP;
        end
        S_PARITY: if (rx_tk == 4'd15) begin
          rx_pbit_nxt = rx_s2;
          rx_st_nxt   = S_STOP;
        end
        S_STOP: if (rx_tk == 4'd15) begin
          rx_st_nxt = S_IDLE;
          if (!rx_s2 || (PARITY_EN && (((^rx_sh) ^ rx_pbit) != PARITY_ODD)))
            rx_bad = 1'b1;
          else
            rx_done = 1'b1;
        end
        default: rx_st_nxt = S_IDLE;
      endcase
    end
  end

  // RX FIFO and interrupt handshake
  logic [DATA_BITS-1:0] rx_mem [DEPTH];
  logic [FIFO_AW:0]     rx_wp, rx_rp;
  logic                 rx_full, rx_empty, rx_push, rx_pop, rx_drop;
  logic                 int_req_q, frame_err_q, overrun_q;
  logic [DATA_BITS-1:0] data_out_q;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) &&
                    (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);
  assign rx_pop   = bus.int_ack & int_req_q;
  assign rx_push  = rx_done & (~rx_full | rx_pop);
  assign rx_drop  = rx_done & rx_full & ~rx_pop;

  assign bus.int_req      = int_req_q;
  assign bus.data_out     = data_out_q;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_overrun   = overrun_q;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp       <= '0;
      rx_rp       <= '0;
      int_req_q   <= 1'b0;
      data_out_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rx_pop)  rx_rp <= rx_rp + PTR_ONE;
      if (bus.int_ack) begin
        int_req_q <= 1'b0;
      end else if (!int_req_q && !rx_empty) begin
        int_req_q  <= 1'b1;
        data_out_q <= rx_mem[rx_rp[FIFO_AW-1:0]];
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      if (rx_bad)           frame_err_q <= 1'b1;
      else if (bus.err_clr) frame_err_q <= 1'b0;
      if (rx_drop)          overrun_q <= 1'b1;
      else if (bus.err_clr) overrun_q <= 1'b0;
    end
  end
endmodule
